// File: rtl/rom_loader.sv
// Write side of the instruction ROM: loads a big-endian word count plus that many
// big-endian instruction words from a byte stream while holding the CPU in reset.
module rom_loader #(
    parameter int ROM_WORDS  = 32768,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [7:0]            in_byte,
    output logic                  in_ready,
    output logic                  rom_write_enable,
    output logic [ADDR_WIDTH-1:0] rom_address,
    output logic [15:0]           rom_data,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH-1:0] words_written,
    output logic [2:0]            dbg_state
);

    // Handshake: a byte moves on any posedge where in_valid && in_ready; the source
    // must hold in_byte stable while in_valid is high and in_ready is low.
    typedef enum logic [2:0] {
        S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_WRITE, S_DONE, S_ERROR
    } state_e;

    localparam logic [16:0] ROM_LIMIT = 17'(ROM_WORDS);

    state_e                state_q, state_d;
    logic [15:0]           length_q, length_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [15:0]           data_q, data_d;
    logic [ADDR_WIDTH-1:0] ww_q, ww_d;

    logic                  xfer;
    logic [15:0]           len_full;
    logic [ADDR_WIDTH-1:0] ww_inc;

    assign in_ready = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                      (state_q == S_DATA_HI) || (state_q == S_DATA_LO);
    assign xfer     = in_valid && in_ready;
    assign len_full = {length_q[15:8], in_byte};
    assign ww_inc   = ww_q + ADDR_WIDTH'(1);

    always_comb begin
        state_d  = state_q;
        length_d = length_q;
        addr_d   = addr_q;
        data_d   = data_q;
        ww_d     = ww_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_d = S_LEN_HI;
                    addr_d  = '0;
                    ww_d    = '0;
                end
            end
            S_LEN_HI: begin
                if (xfer) begin
                    length_d[15:8] = in_byte;
                    state_d        = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                // Judge the header on the completed length, including this byte.
                if (xfer) begin
                    length_d = len_full;
                    if (len_full == 16'd0)
                        state_d = S_DONE;
                    else if ({1'b0, len_full} > ROM_LIMIT)
                        state_d = S_ERROR;
                    else
                        state_d = S_DATA_HI;
                end
            end
            S_DATA_HI: begin
                if (xfer) begin
                    data_d[15:8] = in_byte;
                    state_d      = S_DATA_LO;
                end
            end
            S_DATA_LO: begin
                if (xfer) begin
                    data_d[7:0] = in_byte;
                    state_d     = S_WRITE;
                end
            end
            S_WRITE: begin
                addr_d  = addr_q + ADDR_WIDTH'(1);
                ww_d    = ww_inc;
                state_d = (32'(ww_inc) == 32'(length_q)) ? S_DONE : S_DATA_HI;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            length_q <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            ww_q     <= '0;
        end else begin
            state_q  <= state_d;
            length_q <= length_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            ww_q     <= ww_d;
        end
    end

    // cpu_hold falls in the same cycle done/error rises, so the PC leaves reset at 0.
    assign rom_write_enable = (state_q == S_WRITE);
    assign cpu_hold         = !((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERROR));
    assign done             = (state_q == S_DONE);
    assign error            = (state_q == S_ERROR);
    assign rom_address      = addr_q;
    assign rom_data         = data_q;
    assign words_written    = ww_q;
    assign dbg_state        = state_q;

endmodule

// File: tb/tb_rom_loader.sv
// Bench for rom_loader: table-driven loads, hand-written reset/abort sequence and
// randomized loads checked against a stream-level reference model.
module tb_rom_loader;
  localparam int ROM_W = 4;
  localparam int AW    = 16;

  logic          clk = 1'b0;
  logic          reset, start, in_valid;
  logic [7:0]    in_byte;
  logic          in_ready, rom_write_enable, cpu_hold, done, error;
  logic [AW-1:0] rom_address, words_written;
  logic [15:0]   rom_data;
  logic [2:0]    dbg_state;

  rom_loader #(.ROM_WORDS(ROM_W), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_byte(in_byte),
    .in_ready(in_ready), .rom_write_enable(rom_write_enable), .rom_address(rom_address),
    .rom_data(rom_data), .cpu_hold(cpu_hold), .done(done), .error(error),
    .words_written(words_written), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int writes_seen = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every write strobe must match the next expected {addr, data}.
  always @(negedge clk) begin
    if (rom_write_enable === 1'b1) begin
      writes_seen++;
      chk("write_in_ready_low", {31'b0, in_ready}, 32'd0);
      chk("write_cpu_hold", {31'b0, cpu_hold}, 32'd1);
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {rom_address, rom_data}, 32'hFFFF_FFFF);
      end else begin
        chk("write_addr_data", {rom_address, rom_data}, exp_q.pop_front());
      end
    end
  end

  typedef struct {
    int          nb;
    logic [79:0] bytes;
    int          stall;
    bit          mid_start;
    bit          e_done;
    bit          e_err;
    int          e_ww;
  } vec_t;

  // Reference model: works on the raw stream, not on the loader's states.
  task automatic model_load(input logic [79:0] b, output bit d, output bit e, output int ww);
    int n;
    n  = int'(b[79:64]);
    d  = 1'b0;
    e  = 1'b0;
    ww = 0;
    if (n == 0) d = 1'b1;
    else if (n > ROM_W) e = 1'b1;
    else begin
      d  = 1'b1;
      ww = n;
    end
    for (int k = 0; k < ww; k++) exp_q.push_back({16'(k), b[63-16*k -: 16]});
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_cpu_hold", {31'b0, cpu_hold}, 32'd1);
    chk("start_done_clr", {31'b0, done}, 32'd0);
    chk("start_err_clr", {31'b0, error}, 32'd0);
    chk("start_ww_clr", 32'(words_written), 32'd0);
    chk("start_addr_clr", 32'(rom_address), 32'd0);
  endtask

  task automatic send_byte(input logic [7:0] b, input int stall, input bit mid_start);
    int cnt;
    for (int s = 0; s < stall; s++) begin
      in_valid = 1'b0;
      start = mid_start ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
    end
    start    = 1'b0;
    in_valid = 1'b1;
    in_byte  = b;
    cnt = 0;
    while (in_ready !== 1'b1 && cnt < 50) begin
      chk("in_ready_low_only_in_write", {31'b0, rom_write_enable}, 32'd1);
      @(negedge clk);
      cnt++;
    end
    if (cnt >= 50) chk("byte_accept_timeout", 32'(cnt), 32'd0);
    chk("hold_during_load", {31'b0, cpu_hold}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic run_load(input vec_t v, input string tag);
    int cnt;
    bit md, me;
    int mww;
    model_load(v.bytes, md, me, mww);
    do_start();
    for (int i = 0; i < v.nb; i++) send_byte(v.bytes[79-8*i -: 8], v.stall, v.mid_start);
    if (v.nb == 2) begin
      chk({tag, "_hdr_done_next_cycle"}, {31'b0, done}, {31'b0, v.e_done});
      chk({tag, "_hdr_err_next_cycle"}, {31'b0, error}, {31'b0, v.e_err});
    end
    cnt = 0;
    while (!(done === 1'b1 || error === 1'b1) && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    if (cnt >= 20) chk({tag, "_finish_timeout"}, 32'(cnt), 32'd0);
    chk({tag, "_done"}, {31'b0, done}, {31'b0, v.e_done});
    chk({tag, "_error"}, {31'b0, error}, {31'b0, v.e_err});
    chk({tag, "_words_written"}, 32'(words_written), 32'(v.e_ww));
    chk({tag, "_rom_address"}, 32'(rom_address), 32'(v.e_ww));
    chk({tag, "_cpu_hold"}, {31'b0, cpu_hold}, 32'd0);
    chk({tag, "_in_ready"}, {31'b0, in_ready}, 32'd0);
    chk({tag, "_exp_q_drained"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  vec_t tbl[7];
  vec_t rv;

  initial begin
    tbl[0] = '{6,  80'h0002_1234_ABCD_0000_0000, 0, 1'b0, 1'b1, 1'b0, 2};
    tbl[1] = '{2,  80'h0000_0000_0000_0000_0000, 0, 1'b0, 1'b1, 1'b0, 0};
    tbl[2] = '{2,  80'h0005_0000_0000_0000_0000, 0, 1'b0, 1'b0, 1'b1, 0};
    tbl[3] = '{6,  80'h0002_1234_ABCD_0000_0000, 3, 1'b1, 1'b1, 1'b0, 2};
    tbl[4] = '{10, 80'h0004_0A0B_0C0D_F00F_FFFF, 1, 1'b1, 1'b1, 1'b0, 4};
    tbl[5] = '{2,  80'h8001_0000_0000_0000_0000, 0, 1'b0, 1'b0, 1'b1, 0};
    tbl[6] = '{4,  80'h0001_7788_0000_0000_0000, 0, 1'b0, 1'b1, 1'b0, 1};

    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_byte = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_outputs", {in_ready, rom_write_enable, cpu_hold, done, error}, 32'd0);
    chk("rst_addr_data", {rom_address, rom_data}, 32'd0);
    chk("rst_words_written", 32'(words_written), 32'd0);

    for (int i = 0; i < 7; i++) run_load(tbl[i], $sformatf("tbl%0d", i));

    // Reset mid-load: only the first word lands, then everything returns to reset values.
    begin
      bit md, me;
      int mww;
      writes_seen = 0;
      exp_q.push_back({16'h0000, 16'h1111});
      do_start();
      send_byte(8'h00, 0, 1'b0);
      send_byte(8'h03, 0, 1'b0);
      send_byte(8'h11, 0, 1'b0);
      send_byte(8'h11, 0, 1'b0);
      send_byte(8'h22, 0, 1'b0);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("midrst_outputs", {in_ready, rom_write_enable, cpu_hold, done, error}, 32'd0);
      chk("midrst_addr_data", {rom_address, rom_data}, 32'd0);
      chk("midrst_words_written", 32'(words_written), 32'd0);
      repeat (5) @(negedge clk);
      chk("midrst_single_write", 32'(writes_seen), 32'd1);
      chk("midrst_exp_q", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      run_load('{4, 80'h0001_5566_0000_0000_0000, 0, 1'b0, 1'b1, 1'b0, 1}, "after_rst");
    end

    for (int r = 0; r < 25; r++) begin
      bit md, me;
      int mww, n;
      n = $urandom_range(0, 6);
      rv.bytes = {8'h00, 8'(n), 32'($urandom), 32'($urandom)};
      rv.nb = (n <= ROM_W) ? 2 + 2 * n : 2;
      rv.stall = $urandom_range(0, 2);
      rv.mid_start = 1'($urandom_range(0, 1));
      model_load(rv.bytes, md, me, mww);
      exp_q.delete();
      rv.e_done = md; rv.e_err = me; rv.e_ww = mww;
      run_load(rv, $sformatf("rnd%0d", r));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
